// File: rtl/iob_fifo_sync_asym_thr.sv
// Single-clock FIFO with asymmetric write/read widths, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module iob_fifo_sync_asym_thr #(
   parameter int W_DATA_W = 8,
   parameter int R_DATA_W = 32,
   parameter int ADDR_W   = 4
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic                w_en_i,
   input  logic [W_DATA_W-1:0] w_data_i,
   input  logic                r_en_i,
   output logic [R_DATA_W-1:0] r_data_o,
   output logic                empty_o,
   output logic                full_o,
   output logic [ADDR_W:0]     level_o,
   input  logic [ADDR_W:0]     af_thr_i,
   input  logic [ADDR_W:0]     ae_thr_i,
   output logic                almost_full_o,
   output logic                almost_empty_o,
   output logic                w_ovf_o,
   output logic                r_udf_o,
   input  logic                err_clr_i
);

   localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
   localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W;
   localparam int R         = MAXDATA_W / MINDATA_W;
   localparam int R_LOG     = $clog2(R);
   localparam int FIFO_SIZE = 2 ** ADDR_W;
   localparam int W_INCR    = (W_DATA_W > R_DATA_W) ? R : 1;
   localparam int R_INCR    = (R_DATA_W > W_DATA_W) ? R : 1;
   localparam int ROW_W     = (ADDR_W > R_LOG) ? ADDR_W - R_LOG : 1;
   localparam int ROWS      = 2 ** ROW_W;
   localparam int LVL_W     = ADDR_W + 1;

   localparam logic [LVL_W-1:0] WR_LIMIT = LVL_W'(FIFO_SIZE - W_INCR);
   localparam logic [LVL_W-1:0] RD_LIMIT = LVL_W'(R_INCR);
   localparam logic [LVL_W-1:0] W_STEP   = LVL_W'(W_INCR);
   localparam logic [LVL_W-1:0] R_STEP   = LVL_W'(R_INCR);

   logic [LVL_W-1:0]    level_q, level_d;
   logic [LVL_W-1:0]    wPtr_q, wPtr_d;
   logic [LVL_W-1:0]    rPtr_q, rPtr_d;
   logic [R_DATA_W-1:0] rData_q, rData_d;
   logic                wOvf_q, wOvf_d;
   logic                rUdf_q, rUdf_d;

   logic                wAcc, rAcc, memWe;
   logic [LVL_W-1:0]    wAdd, rSub;
   logic [ROW_W-1:0]    wRow, rRow;
   logic [R_DATA_W-1:0] readWord;

   logic [MAXDATA_W-1:0] mem_q [ROWS];

   // Both sides are judged against the registered level, so a read cannot
   // free room for a same-cycle write and a write cannot feed a same-cycle read.
   always_comb begin
      wAcc  = w_en_i & cke_i & (level_q <= WR_LIMIT);
      rAcc  = r_en_i & cke_i & (level_q >= RD_LIMIT);
      memWe = wAcc & ~rst_i;
      wAdd  = wAcc ? W_STEP : '0;
      rSub  = rAcc ? R_STEP : '0;
   end

   always_comb begin
      level_d = level_q;
      wPtr_d  = wPtr_q;
      rPtr_d  = rPtr_q;
      rData_d = rData_q;
      wOvf_d  = wOvf_q;
      rUdf_d  = rUdf_q;
      if (rst_i) begin
         level_d = '0;
         wPtr_d  = '0;
         rPtr_d  = '0;
         rData_d = '0;
         wOvf_d  = 1'b0;
         rUdf_d  = 1'b0;
      end else if (cke_i) begin
         level_d = level_q + wAdd - rSub;
         if (wAcc) wPtr_d = wPtr_q + W_STEP;
         if (rAcc) begin
            rPtr_d  = rPtr_q + R_STEP;
            rData_d = readWord;
         end
         // A fresh error in the clearing cycle keeps its flag set.
         wOvf_d = (w_en_i & ~wAcc) | (wOvf_q & ~err_clr_i);
         rUdf_d = (r_en_i & ~rAcc) | (rUdf_q & ~err_clr_i);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         level_q <= '0;
         wPtr_q  <= '0;
         rPtr_q  <= '0;
         rData_q <= '0;
         wOvf_q  <= 1'b0;
         rUdf_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         wPtr_q  <= wPtr_d;
         rPtr_q  <= rPtr_d;
         rData_q <= rData_d;
         wOvf_q  <= wOvf_d;
         rUdf_q  <= rUdf_d;
      end
   end

   // Row index is the pointer above the lane bits; with a single row it is 0.
   if (ADDR_W > R_LOG) begin : gRowIdx
      assign wRow = wPtr_q[ADDR_W-1:R_LOG];
      assign rRow = rPtr_q[ADDR_W-1:R_LOG];
   end else begin : gRowZero
      assign wRow = '0;
      assign rRow = '0;
   end

   if (W_DATA_W < R_DATA_W) begin : gNarrowWrite
      logic [R_LOG-1:0] wLane;
      assign wLane = wPtr_q[R_LOG-1:0];
      always_ff @(posedge clk_i) begin
         if (memWe) begin
            for (int l = 0; l < R; l++) begin
               if (wLane == R_LOG'(l)) mem_q[wRow][l*MINDATA_W +: MINDATA_W] <= w_data_i;
            end
         end
      end
   end else begin : gWideWrite
      always_ff @(posedge clk_i) begin
         if (memWe) mem_q[wRow] <= w_data_i;
      end
   end

   if (R_DATA_W < W_DATA_W) begin : gNarrowRead
      logic [R_LOG-1:0]     rLane;
      logic [MAXDATA_W-1:0] rowWord;
      assign rLane   = rPtr_q[R_LOG-1:0];
      assign rowWord = mem_q[rRow];
      always_comb begin
         readWord = '0;
         for (int l = 0; l < R; l++) begin
            if (rLane == R_LOG'(l)) readWord = rowWord[l*MINDATA_W +: MINDATA_W];
         end
      end
   end else begin : gWideRead
      assign readWord = mem_q[rRow];
   end

   assign r_data_o       = rData_q;
   assign level_o        = level_q;
   assign full_o         = level_q > WR_LIMIT;
   assign empty_o        = level_q < RD_LIMIT;
   assign almost_full_o  = level_q >= af_thr_i;
   assign almost_empty_o = level_q <= ae_thr_i;
   assign w_ovf_o        = wOvf_q;
   assign r_udf_o        = rUdf_q;

endmodule

// File: tb/tb_iob_fifo_sync_asym_thr.sv
// Directed bench for iob_fifo_sync_asym_thr: 8->32, 32->8 and 32->32
// instances driven through a linear sequence of steps.
module tb_iob_fifo_sync_asym_thr;

   logic clk;
   logic arstN;
   logic cke;
   logic rst;
   logic errClr;

   int checks = 0;
   int errors = 0;

   // Instance A: 8-bit write, 32-bit read
   logic        wEnA, rEnA;
   logic [7:0]  wDataA;
   logic [31:0] rDataA;
   logic        emptyA, fullA, afA, aeA, ovfA, udfA;
   logic [4:0]  levelA;
   logic [4:0]  afThrA, aeThrA;

   // Instance B: 32-bit write, 8-bit read
   logic        wEnB, rEnB;
   logic [31:0] wDataB;
   logic [7:0]  rDataB;
   logic        emptyB, fullB, afB, aeB, ovfB, udfB;
   logic [4:0]  levelB;
   logic [4:0]  afThrB, aeThrB;

   // Instance C: symmetric 32-bit
   logic        wEnC, rEnC;
   logic [31:0] wDataC;
   logic [31:0] rDataC;
   logic        emptyC, fullC, afC, aeC, ovfC, udfC;
   logic [4:0]  levelC;
   logic [4:0]  afThrC, aeThrC;

   iob_fifo_sync_asym_thr #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) uA (
      .clk_i(clk), .arst_n_i(arstN), .cke_i(cke), .rst_i(rst),
      .w_en_i(wEnA), .w_data_i(wDataA), .r_en_i(rEnA), .r_data_o(rDataA),
      .empty_o(emptyA), .full_o(fullA), .level_o(levelA),
      .af_thr_i(afThrA), .ae_thr_i(aeThrA),
      .almost_full_o(afA), .almost_empty_o(aeA),
      .w_ovf_o(ovfA), .r_udf_o(udfA), .err_clr_i(errClr)
   );

   iob_fifo_sync_asym_thr #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) uB (
      .clk_i(clk), .arst_n_i(arstN), .cke_i(cke), .rst_i(rst),
      .w_en_i(wEnB), .w_data_i(wDataB), .r_en_i(rEnB), .r_data_o(rDataB),
      .empty_o(emptyB), .full_o(fullB), .level_o(levelB),
      .af_thr_i(afThrB), .ae_thr_i(aeThrB),
      .almost_full_o(afB), .almost_empty_o(aeB),
      .w_ovf_o(ovfB), .r_udf_o(udfB), .err_clr_i(errClr)
   );

   iob_fifo_sync_asym_thr #(.W_DATA_W(32), .R_DATA_W(32), .ADDR_W(4)) uC (
      .clk_i(clk), .arst_n_i(arstN), .cke_i(cke), .rst_i(rst),
      .w_en_i(wEnC), .w_data_i(wDataC), .r_en_i(rEnC), .r_data_o(rDataC),
      .empty_o(emptyC), .full_o(fullC), .level_o(levelC),
      .af_thr_i(afThrC), .ae_thr_i(aeThrC),
      .almost_full_o(afC), .almost_empty_o(aeC),
      .w_ovf_o(ovfC), .r_udf_o(udfC), .err_clr_i(errClr)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, leaving time 1 unit past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      arstN  = 1'b0;
      cke    = 1'b1;
      rst    = 1'b0;
      errClr = 1'b0;
      wEnA = 1'b0; rEnA = 1'b0; wDataA = '0; afThrA = 5'd12; aeThrA = 5'd4;
      wEnB = 1'b0; rEnB = 1'b0; wDataB = '0; afThrB = 5'd16; aeThrB = 5'd0;
      wEnC = 1'b0; rEnC = 1'b0; wDataC = '0; afThrC = 5'd16; aeThrC = 5'd0;

      #12 arstN = 1'b1;
      #1;
      $display("[TB] reset released");
      checkOutput("rstA_empty", 32'(emptyA), 32'd1);
      checkOutput("rstA_full",  32'(fullA),  32'd0);
      checkOutput("rstA_level", 32'(levelA), 32'd0);
      checkOutput("rstA_rdata", rDataA,      32'h0);
      checkOutput("rstA_ae",    32'(aeA),    32'd1);
      checkOutput("rstA_af",    32'(afA),    32'd0);
      checkOutput("rstA_ovf",   32'(ovfA),   32'd0);
      checkOutput("rstB_rdata", 32'(rDataB), 32'h0);
      checkOutput("rstC_af",    32'(afC),    32'd0);

      // Pack order on the 8->32 instance
      wEnA = 1'b1; wDataA = 8'h11; applyStimulus(1);
      checkOutput("packA_level1", 32'(levelA), 32'd1);
      checkOutput("packA_empty1", 32'(emptyA), 32'd1);
      wDataA = 8'h22; applyStimulus(1);
      wDataA = 8'h33; applyStimulus(1);
      checkOutput("packA_empty3", 32'(emptyA), 32'd1);
      wDataA = 8'h44; applyStimulus(1);
      checkOutput("packA_empty4", 32'(emptyA), 32'd0);
      checkOutput("packA_level4", 32'(levelA), 32'd4);
      wEnA = 1'b0; rEnA = 1'b1; applyStimulus(1);
      rEnA = 1'b0;
      checkOutput("packA_rdata", rDataA, 32'h44332211);
      checkOutput("packA_level0", 32'(levelA), 32'd0);
      checkOutput("packA_emptyEnd", 32'(emptyA), 32'd1);

      // Read from empty is rejected and flagged
      rEnA = 1'b1; applyStimulus(1);
      rEnA = 1'b0;
      checkOutput("udfA_set", 32'(udfA), 32'd1);
      checkOutput("udfA_rdataHold", rDataA, 32'h44332211);
      errClr = 1'b1; applyStimulus(1);
      errClr = 1'b0;
      checkOutput("udfA_clr", 32'(udfA), 32'd0);

      // Fill to full, watching almost-full cross the threshold
      for (int i = 0; i < 16; i++) begin
         wEnA = 1'b1; wDataA = 8'(8'h50 + i);
         applyStimulus(1);
         if (i == 10) checkOutput("thrA_af11", 32'(afA), 32'd0);
         if (i == 11) checkOutput("thrA_af12", 32'(afA), 32'd1);
      end
      checkOutput("fillA_full", 32'(fullA), 32'd1);
      checkOutput("fillA_level", 32'(levelA), 32'd16);
      wDataA = 8'hEE; applyStimulus(1);
      wEnA = 1'b0;
      checkOutput("ovfA_set", 32'(ovfA), 32'd1);
      checkOutput("ovfA_level", 32'(levelA), 32'd16);
      errClr = 1'b1; applyStimulus(1);
      errClr = 1'b0;
      checkOutput("ovfA_clr", 32'(ovfA), 32'd0);

      // Concurrent read+write while full: write dropped, read taken
      wEnA = 1'b1; rEnA = 1'b1; wDataA = 8'hEF; applyStimulus(1);
      wEnA = 1'b0;
      checkOutput("simA_level", 32'(levelA), 32'd12);
      checkOutput("simA_ovf", 32'(ovfA), 32'd1);
      checkOutput("simA_rdata", rDataA, 32'h53525150);
      applyStimulus(1);
      checkOutput("drainA_level8", 32'(levelA), 32'd8);
      checkOutput("drainA_ae8", 32'(aeA), 32'd0);
      checkOutput("drainA_af8", 32'(afA), 32'd0);
      applyStimulus(1);
      rEnA = 1'b0;
      checkOutput("drainA_level4", 32'(levelA), 32'd4);
      checkOutput("drainA_ae4", 32'(aeA), 32'd1);
      checkOutput("drainA_rdata", rDataA, 32'h5B5A5958);

      // Synchronous clear mid-stream
      rst = 1'b1; applyStimulus(1);
      rst = 1'b0;
      checkOutput("srstA_level", 32'(levelA), 32'd0);
      checkOutput("srstA_empty", 32'(emptyA), 32'd1);
      checkOutput("srstA_rdata", rDataA, 32'h0);
      checkOutput("srstA_ovf", 32'(ovfA), 32'd0);

      // Clock enable low: nothing accepted, no error raised
      cke = 1'b0; wEnA = 1'b1; rEnA = 1'b1; applyStimulus(1);
      wEnA = 1'b0; rEnA = 1'b0; cke = 1'b1;
      checkOutput("ckeA_level", 32'(levelA), 32'd0);
      checkOutput("ckeA_ovf", 32'(ovfA), 32'd0);
      checkOutput("ckeA_udf", 32'(udfA), 32'd0);

      // Error set wins over a same-cycle clear
      rEnA = 1'b1; errClr = 1'b1; applyStimulus(1);
      rEnA = 1'b0; errClr = 1'b0;
      checkOutput("setWinsA_udf", 32'(udfA), 32'd1);

      // Wide->narrow unpack order on the 32->8 instance
      wEnB = 1'b1; wDataB = 32'hA1B2C3D4; applyStimulus(1);
      wEnB = 1'b0;
      checkOutput("unpB_level", 32'(levelB), 32'd4);
      checkOutput("unpB_empty", 32'(emptyB), 32'd0);
      rEnB = 1'b1; applyStimulus(1);
      checkOutput("unpB_r0", 32'(rDataB), 32'hD4);
      applyStimulus(1);
      checkOutput("unpB_r1", 32'(rDataB), 32'hC3);
      applyStimulus(1);
      checkOutput("unpB_r2", 32'(rDataB), 32'hB2);
      applyStimulus(1);
      checkOutput("unpB_r3", 32'(rDataB), 32'hA1);
      checkOutput("unpB_udfBefore", 32'(udfB), 32'd0);
      applyStimulus(1);
      rEnB = 1'b0;
      checkOutput("unpB_udf", 32'(udfB), 32'd1);
      checkOutput("unpB_rdataHold", 32'(rDataB), 32'hA1);
      checkOutput("unpB_level0", 32'(levelB), 32'd0);

      // Symmetric instance: concurrent read+write holds level
      for (int i = 0; i < 8; i++) begin
         wEnC = 1'b1; wDataC = 32'h1000_0000 + 32'(i);
         applyStimulus(1);
      end
      checkOutput("symC_level8", 32'(levelC), 32'd8);
      wDataC = 32'h1000_0008; rEnC = 1'b1; applyStimulus(1);
      rEnC = 1'b0;
      checkOutput("symC_simLevel", 32'(levelC), 32'd8);
      checkOutput("symC_simRdata", rDataC, 32'h1000_0000);
      for (int i = 9; i < 17; i++) begin
         wEnC = 1'b1; wDataC = 32'h1000_0000 + 32'(i);
         applyStimulus(1);
      end
      checkOutput("symC_full", 32'(fullC), 32'd1);
      checkOutput("symC_af", 32'(afC), 32'd1);
      checkOutput("symC_ovfBefore", 32'(ovfC), 32'd0);
      wDataC = 32'hDEAD_BEEF; rEnC = 1'b1; applyStimulus(1);
      wEnC = 1'b0; rEnC = 1'b0;
      checkOutput("symC_fullSimLevel", 32'(levelC), 32'd15);
      checkOutput("symC_fullSimOvf", 32'(ovfC), 32'd1);
      checkOutput("symC_fullSimRdata", rDataC, 32'h1000_0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
